// File: rtl/platform_spawn_scheduler.sv
// Platform spawn scheduler: walks the level record table one record at a time,
// holds each record until game time reaches its launch time, then hands it to
// the lowest-index free platform slot.
module platform_spawn_scheduler #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned MAXIMUM_TIMES = 30,
  parameter int unsigned NUM_SLOTS     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [MAXIMUM_TIMES-1:0] i_current_time,
  output logic [ADDR_WIDTH-1:0]    o_rom_addr,
  output logic                     o_rec_sync,
  input  logic                     i_rec_ready,
  input  logic [MAXIMUM_TIMES-1:0] i_rec_time,
  input  logic [9:0]               i_rec_w,
  output logic                     o_rec_ack,
  input  logic [NUM_SLOTS-1:0]     i_slot_active,
  output logic [NUM_SLOTS-1:0]     o_slot_load,
  output logic                     o_slots_full,
  output logic                     o_level_done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StWaitTime,
    StAlloc,
    StAdvance,
    StDone
  } state_e;

  state_e                   r_state;
  logic [ADDR_WIDTH-1:0]    r_rom_addr;
  logic                     r_rec_sync;
  logic                     r_rec_ack;
  logic [NUM_SLOTS-1:0]     r_slot_load;
  logic                     r_slots_full;
  logic                     r_level_done;
  logic [MAXIMUM_TIMES-1:0] r_launch_time;
  logic                     r_is_term;

  state_e                   w_state;
  logic [ADDR_WIDTH-1:0]    w_rom_addr;
  logic                     w_rec_sync;
  logic                     w_rec_ack;
  logic [NUM_SLOTS-1:0]     w_slot_load;
  logic                     w_slots_full;
  logic                     w_level_done;
  logic [MAXIMUM_TIMES-1:0] w_launch_time;
  logic                     w_is_term;

  logic [NUM_SLOTS-1:0]     w_free;
  logic [NUM_SLOTS-1:0]     w_pick;
  logic                     w_found;
  logic                     w_last_addr;
  logic                     w_due;

  // Lowest-index free slot as a one-hot mask (zero when every slot is busy).
  always_comb begin
    w_free  = ~i_slot_active;
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_free[i] && !w_found) begin
        w_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Table end and launch-time comparisons; the table never wraps.
  always_comb begin
    w_last_addr = (r_rom_addr == {ADDR_WIDTH{1'b1}});
    w_due       = (i_current_time >= r_launch_time);
  end

  // Next-state and next-output logic; abort overrides everything, including start.
  always_comb begin
    w_state       = r_state;
    w_rom_addr    = r_rom_addr;
    w_rec_sync    = r_rec_sync;
    w_rec_ack     = 1'b0;
    w_slot_load   = '0;
    w_slots_full  = r_slots_full;
    w_level_done  = r_level_done;
    w_launch_time = r_launch_time;
    w_is_term     = r_is_term;

    if (i_abort) begin
      w_state      = StIdle;
      w_rom_addr   = '0;
      w_rec_sync   = 1'b1;
      w_slots_full = 1'b0;
      w_level_done = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state      = StFetch;
            w_rom_addr   = '0;
            w_rec_sync   = 1'b0;
            w_level_done = 1'b0;
          end
        end
        StFetch: begin
          if (i_rec_ready) begin
            w_launch_time = i_rec_time;
            w_is_term     = (i_rec_w == 10'd0);
            w_rec_sync    = 1'b1;
            w_state       = StCheck;
          end
        end
        StCheck: begin
          if (r_is_term) begin
            w_state      = StDone;
            w_level_done = 1'b1;
          end else begin
            w_state = StWaitTime;
          end
        end
        StWaitTime: begin
          if (w_due) w_state = StAlloc;
        end
        StAlloc: begin
          // Decision uses this cycle's sampled busy flags; no re-check afterwards.
          if (w_found) begin
            w_slot_load  = w_pick;
            w_rec_ack    = 1'b1;
            w_slots_full = 1'b0;
            w_state      = StAdvance;
          end else begin
            w_slots_full = 1'b1;
          end
        end
        StAdvance: begin
          if (w_last_addr) begin
            w_state      = StDone;
            w_level_done = 1'b1;
          end else begin
            w_rom_addr = r_rom_addr + 1'b1;
            w_rec_sync = 1'b0;
            w_state    = StFetch;
          end
        end
        default: begin
          w_state    = StIdle;
          w_rom_addr = '0;
          w_rec_sync = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_rom_addr    <= '0;
      r_rec_sync    <= 1'b1;
      r_rec_ack     <= 1'b0;
      r_slot_load   <= '0;
      r_slots_full  <= 1'b0;
      r_level_done  <= 1'b0;
      r_launch_time <= '0;
      r_is_term     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rom_addr    <= w_rom_addr;
      r_rec_sync    <= w_rec_sync;
      r_rec_ack     <= w_rec_ack;
      r_slot_load   <= w_slot_load;
      r_slots_full  <= w_slots_full;
      r_level_done  <= w_level_done;
      r_launch_time <= w_launch_time;
      r_is_term     <= w_is_term;
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_rec_sync   = r_rec_sync;
  assign o_rec_ack    = r_rec_ack;
  assign o_slot_load  = r_slot_load;
  assign o_slots_full = r_slots_full;
  assign o_level_done = r_level_done;

endmodule

// File: tb/tb_platform_spawn_scheduler.sv
// Randomized scoreboard bench for platform_spawn_scheduler: a ROM-reader model
// queues every record it hands over; a monitor predicts, from the record rules,
// when and where each record must be loaded and checks the DUT every cycle.
module tb_platform_spawn_scheduler;
  localparam int unsigned AW = 2;
  localparam int unsigned TW = 30;
  localparam int unsigned NS = 4;
  localparam int LAST_ADDR = 3;

  logic          clk;
  logic          i_reset, i_start, i_abort, i_rec_ready;
  logic [TW-1:0] i_current_time, i_rec_time;
  logic [9:0]    i_rec_w;
  logic [NS-1:0] i_slot_active;
  logic [AW-1:0] o_rom_addr;
  logic          o_rec_sync, o_rec_ack, o_slots_full, o_level_done;
  logic [NS-1:0] o_slot_load;

  platform_spawn_scheduler #(
    .ADDR_WIDTH   (AW),
    .MAXIMUM_TIMES(TW),
    .NUM_SLOTS    (NS)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_current_time(i_current_time),
    .o_rom_addr    (o_rom_addr),
    .o_rec_sync    (o_rec_sync),
    .i_rec_ready   (i_rec_ready),
    .i_rec_time    (i_rec_time),
    .i_rec_w       (i_rec_w),
    .o_rec_ack     (o_rec_ack),
    .i_slot_active (i_slot_active),
    .o_slot_load   (o_slot_load),
    .o_slots_full  (o_slots_full),
    .o_level_done  (o_level_done)
  );

  typedef struct {
    int          addr;
    int unsigned launch;
    bit          term;
    int          c0;     // cycle of the clock edge that consumes the record
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Stimulus controls, written by the main sequence, applied by the drivers.
  int unsigned tbl_time[4];
  int          tbl_w[4];
  bit          start_req = 0, abort_req = 0, time_zero = 0, clear_busy = 0;
  bit          force_mode = 0;
  logic [3:0]  force_val = 4'h0;
  int          dur_lo = 1, dur_hi = 8;
  int          busy[4] = '{0, 0, 0, 0};
  int unsigned cur_time = 100;

  // Monitor-side reference state.
  bit          mdl_run = 0, mdl_fetch = 0, mdl_done = 0;
  int          mdl_addr = 0, adv_at = -1, done_at = -1;
  int unsigned prev_time = 0;
  int          ack_cnt = 0;
  logic [3:0]  ld_log[$];
  int unsigned ld_time[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0] lowest_free(input logic [3:0] act);
    for (int i = 0; i < 4; i++) if (!act[i]) return 4'(1 << i);
    return 4'h0;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drivers: game clock, control pulses, slot controllers and ROM reader.
  always @(negedge clk) begin
    #1;
    if (time_zero) begin
      cur_time  = 0;
      time_zero = 0;
    end else begin
      cur_time++;
    end
    i_current_time = cur_time[TW-1:0];
    i_start   = start_req;
    start_req = 0;
    i_abort   = abort_req;
    abort_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (clear_busy) busy[i] = 0;
      else if (o_slot_load[i]) busy[i] = $urandom_range(dur_hi, dur_lo);
      else if (busy[i] > 0) busy[i]--;
    end
    clear_busy = 0;
    for (int i = 0; i < 4; i++) i_slot_active[i] = force_mode ? force_val[i] : (busy[i] != 0);
    if (!i_reset && !o_rec_sync && !i_abort && $urandom_range(2, 0) != 0) begin
      i_rec_ready = 1'b1;
      i_rec_time  = tbl_time[o_rom_addr][TW-1:0];
      i_rec_w     = 10'(tbl_w[o_rom_addr]);
      q.push_back('{addr: int'(o_rom_addr), launch: tbl_time[o_rom_addr],
                    term: (tbl_w[o_rom_addr] == 0), c0: cyc + 1});
    end else if (!o_rec_sync) begin
      i_rec_ready = 1'b0;
    end else begin
      // Outside FETCH the reader strobe is noise and must be ignored.
      i_rec_ready = 1'($urandom_range(1, 0));
      i_rec_time  = TW'($urandom_range(1000, 0));
      i_rec_w     = 10'($urandom_range(1023, 0));
    end
  end

  // Monitor: predicts each output from the record rules and compares every cycle.
  always @(negedge clk) begin
    bit         due, full;
    logic [3:0] exp_load;
    if (i_reset) begin
      q.delete();
      mdl_run = 0; mdl_fetch = 0; mdl_done = 0; mdl_addr = 0; adv_at = -1; done_at = -1;
    end else if (i_abort) begin
      q.delete();
      mdl_run = 0; mdl_fetch = 0; mdl_done = 0; mdl_addr = 0; adv_at = -1; done_at = -1;
      check("abort_rom_addr", o_rom_addr, 0);
      check("abort_rec_sync", o_rec_sync, 1);
      check("abort_rec_ack", o_rec_ack, 0);
      check("abort_slot_load", o_slot_load, 0);
      check("abort_slots_full", o_slots_full, 0);
      check("abort_level_done", o_level_done, 0);
    end else begin
      if (i_start && !mdl_run) begin
        mdl_run = 1; mdl_fetch = 1; mdl_addr = 0; mdl_done = 0;
      end
      if (cyc == adv_at) begin
        adv_at = -1;
        if (mdl_addr == LAST_ADDR) begin
          mdl_run = 0; mdl_done = 1;
        end else begin
          mdl_addr++; mdl_fetch = 1;
        end
      end
      if (cyc == done_at) begin
        done_at = -1; mdl_run = 0; mdl_done = 1;
      end
      if (q.size() > 0 && q[0].c0 == cyc) begin
        mdl_fetch = 0;
        check("fetch_addr", q[0].addr, mdl_addr);
        if (q[0].term) begin
          done_at = cyc + 1;
          void'(q.pop_front());
        end
      end
      due = 0; full = 0; exp_load = 4'h0;
      if (q.size() > 0 && cyc >= q[0].c0 + 3 && prev_time >= q[0].launch) begin
        if (&i_slot_active) full = 1;
        else begin
          due = 1;
          exp_load = lowest_free(i_slot_active);
        end
      end
      check("slot_load", o_slot_load, exp_load);
      check("rec_ack", o_rec_ack, due);
      check("slots_full", o_slots_full, full);
      check("rec_sync", o_rec_sync, !mdl_fetch);
      check("level_done", o_level_done, mdl_done);
      check("rom_addr", o_rom_addr, mdl_addr);
      if (due) begin
        void'(q.pop_front());
        adv_at = cyc + 1;
      end
    end
    if (o_slot_load != 0) begin
      ld_log.push_back(o_slot_load);
      ld_time.push_back(cur_time);
    end
    if (o_rec_ack) ack_cnt++;
    prev_time = cur_time;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic run_level(input string name, input int budget);
    bit ok = 0;
    start_req = 1;
    step();
    for (int k = 0; k < budget; k++) begin
      step();
      if (o_level_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_full(input string name);
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_slots_full) begin
        ok = 1;
        break;
      end
    end
    check({name, "_full_seen"}, ok, 1);
  endtask

  task automatic set_table(input int unsigned t0, input int unsigned t1, input int unsigned t2,
                           input int unsigned t3, input int w0, input int w1, input int w2,
                           input int w3);
    tbl_time[0] = t0; tbl_time[1] = t1; tbl_time[2] = t2; tbl_time[3] = t3;
    tbl_w[0] = w0; tbl_w[1] = w1; tbl_w[2] = w2; tbl_w[3] = w3;
  endtask

  initial begin
    int  a0;
    bit  ok;
    bit  switched;
    bit  aborted;
    i_reset = 0; i_start = 0; i_abort = 0; i_rec_ready = 0; i_rec_time = '0; i_rec_w = '0;
    i_current_time = '0; i_slot_active = '0;
    set_table(0, 0, 0, 0, 0, 0, 0, 0);
    #2 i_reset = 1;
    #1;
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_rec_sync", o_rec_sync, 1);
    check("rst_rec_ack", o_rec_ack, 0);
    check("rst_slot_load", o_slot_load, 0);
    check("rst_slots_full", o_slots_full, 0);
    check("rst_level_done", o_level_done, 0);
    repeat (2) @(posedge clk);
    #3 i_reset = 0;
    step();

    // Two t=5 records then a terminator, game time from 0, slots stay busy once loaded.
    force_mode = 0; dur_lo = 500; dur_hi = 500; clear_busy = 1;
    set_table(5, 5, 0, 0, 10, 10, 0, 0);
    time_zero = 1;
    ld_log.delete(); ld_time.delete(); a0 = ack_cnt;
    run_level("t2", 200);
    check("t2_acks", ack_cnt - a0, 2);
    check("t2_loads", ld_log.size(), 2);
    if (ld_log.size() >= 2) begin
      check("t2_load0", ld_log[0], 4'b0001);
      check("t2_load1", ld_log[1], 4'b0010);
      check("t2_load0_time_ge5", ld_time[0] >= 5, 1);
    end
    check("t2_done_addr", o_rom_addr, 2);

    // All slots busy: stall with slots_full, then free slot 2.
    force_mode = 1; force_val = 4'b1111; clear_busy = 1;
    set_table(cur_time, 0, 0, 0, 10, 0, 0, 0);
    ld_log.delete();
    start_req = 1;
    wait_full("t3");
    repeat (5) step();
    check("t3_still_full", o_slots_full, 1);
    check("t3_no_load", ld_log.size(), 0);
    force_val = 4'b1011;
    run_level("t3", 100);
    check("t3_loads", ld_log.size(), 1);
    if (ld_log.size() >= 1) check("t3_load", ld_log[0], 4'b0100);
    check("t3_full_clear", o_slots_full, 0);

    // Lowest free slot for two busy patterns.
    force_val = 4'b1010;
    set_table(cur_time, cur_time, 0, 0, 10, 10, 0, 0);
    ld_log.delete(); switched = 0; ok = 0;
    start_req = 1;
    step();
    for (int k = 0; k < 200; k++) begin
      step();
      if (ld_log.size() == 1 && !switched) begin
        force_val = 4'b1011;
        switched = 1;
      end
      if (o_level_done) begin
        ok = 1;
        break;
      end
    end
    check("t4_done", ok, 1);
    check("t4_loads", ld_log.size(), 2);
    if (ld_log.size() >= 2) begin
      check("t4_load0", ld_log[0], 4'b0001);
      check("t4_load1", ld_log[1], 4'b0100);
    end

    // Full table of non-terminators: four loads, stop at the last address.
    force_mode = 0; dur_lo = 1; dur_hi = 3; clear_busy = 1;
    set_table(cur_time, cur_time + 3, cur_time + 6, cur_time + 9, 1, 2, 3, 4);
    a0 = ack_cnt;
    run_level("t5", 300);
    check("t5_acks", ack_cnt - a0, 4);
    check("t5_end_addr", o_rom_addr, 3);
    step();
    check("t5_stays_done", o_level_done, 1);

    // Abort while stalled in allocation, then restart from address 0.
    force_mode = 1; force_val = 4'b1111;
    set_table(cur_time, 0, 0, 0, 10, 0, 0, 0);
    a0 = ack_cnt;
    start_req = 1;
    wait_full("t6");
    abort_req = 1;
    step();
    step();
    check("t6_no_ack", ack_cnt - a0, 0);
    check("t6_idle_addr", o_rom_addr, 0);
    check("t6_idle_sync", o_rec_sync, 1);
    force_val = 4'b0000;
    start_req = 1;
    step();
    step();
    check("t6_refetch_addr", o_rom_addr, 0);
    check("t6_refetch_sync", o_rec_sync, 0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (o_level_done) begin
        ok = 1;
        break;
      end
    end
    check("t6_done", ok, 1);
    check("t6_acks", ack_cnt - a0, 1);

    // Reset while a record waits for a far-future launch time.
    force_mode = 0; clear_busy = 1;
    set_table(cur_time + 1000, 0, 0, 0, 10, 0, 0, 0);
    start_req = 1;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (!o_rec_sync) begin
        ok = 1;
        break;
      end
    end
    check("t1_fetch_seen", ok, 1);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_rec_sync) begin
        ok = 1;
        break;
      end
    end
    check("t1_accept_seen", ok, 1);
    repeat (3) step();
    @(posedge clk);
    #3 i_reset = 1;
    #1;
    check("t1_rom_addr", o_rom_addr, 0);
    check("t1_rec_sync", o_rec_sync, 1);
    check("t1_rec_ack", o_rec_ack, 0);
    check("t1_slot_load", o_slot_load, 0);
    check("t1_slots_full", o_slots_full, 0);
    check("t1_level_done", o_level_done, 0);
    @(posedge clk);
    #3 i_reset = 0;
    step();

    // Randomized levels with stray starts and occasional aborts.
    for (int r = 0; r < 25; r++) begin
      dur_lo = 1; dur_hi = $urandom_range(20, 1); clear_busy = ($urandom_range(3, 0) == 0);
      for (int a = 0; a < 4; a++) begin
        tbl_time[a] = cur_time + $urandom_range(30, 0);
        tbl_w[a]    = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(1023, 1);
      end
      start_req = 1;
      step();
      ok = 0; aborted = 0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(29, 0) == 0) start_req = 1;
        if ($urandom_range(149, 0) == 0) begin
          abort_req = 1;
          aborted = 1;
        end
        step();
        if (aborted) break;
        if (o_level_done) begin
          ok = 1;
          break;
        end
      end
      if (!aborted) check("rand_level_done", ok, 1);
      step();
    end

    repeat (3) step();
    check("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
